bram_lane_fetch: RTL and testbench

BRAM_LANE_FETCH -- requirements
Module: bram_lane_fetch

---
 rtl/bram_lane_fetch.sv | 148 ++++++++++++++
 tb/tb_bram_lane_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_lane_fetch.sv
// Tile fetcher: streams ceil(num_bytes/16) BRAM words into a registered 16-lane output with a per-lane valid mask.
// Optional build macro LANE_FETCH_ZERO_PAD_EN zeroes the data bytes of lanes whose valid bit is clear.

module bram_lane_fetch #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [15:0]          num_bytes,
    input  logic                 stall,
    output logic                 bram_en,
    output logic [ADDR_W-1:0]    bram_addr,
    input  logic [8*LANES-1:0]   bram_rdata,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     valid_data,
    output logic                 busy,
    output logic                 done
);

    localparam int WORD_W = 8 * LANES;
    localparam int CNT_W  = 12;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt, last_idx, last_idx_d;
    logic [LANES-1:0]  tail_mask, tail_mask_d;
    logic              issue, issue_last, accept;

    logic              pend_vld, pend_last;
    logic [LANES-1:0]  pend_mask;

    logic              skid_vld, skid_last;
    logic [WORD_W-1:0] skid_data;
    logic [LANES-1:0]  skid_mask;

    logic              out_last;
    logic              load_vld, load_last;
    logic [WORD_W-1:0] load_data, pad_data;
    logic [LANES-1:0]  load_mask;

    // Index of the final word and its lane mask, taken straight from the request.
    assign last_idx_d  = CNT_W'((num_bytes - 16'd1) >> 4);
    assign tail_mask_d = (num_bytes[3:0] == 4'd0) ? {LANES{1'b1}}
                       : (LANES'(1) << num_bytes[3:0]) - LANES'(1);

    // A read goes out only when nothing can be stranded: no stall and an empty skid slot.
    assign issue      = (state == FETCH) && !stall && !skid_vld;
    assign issue_last = (cnt == last_idx);
    assign accept     = (|valid_data) && !stall;
    assign bram_en    = issue;
    assign bram_addr  = addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == FETCH) || (next_state == DRAIN);
            done  <= (next_state == FINISH);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (num_bytes == 16'd0) ? FINISH : FETCH;
            FETCH:   if (issue && issue_last) next_state = DRAIN;
            DRAIN:   if (accept && out_last) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            cnt       <= '0;
            last_idx  <= '0;
            tail_mask <= '0;
            pend_vld  <= 1'b0;
            pend_last <= 1'b0;
            pend_mask <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr_q    <= base_addr;
                cnt       <= '0;
                last_idx  <= last_idx_d;
                tail_mask <= tail_mask_d;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                cnt    <= cnt + CNT_W'(1);
            end
            pend_vld  <= issue;
            pend_last <= issue && issue_last;
            pend_mask <= issue_last ? tail_mask : {LANES{1'b1}};
        end
    end

    // The skid word is always older than anything arriving from BRAM, so it wins.
    always_comb begin
        load_vld  = skid_vld || pend_vld;
        load_data = skid_vld ? skid_data : bram_rdata;
        load_mask = skid_vld ? skid_mask : pend_mask;
        load_last = skid_vld ? skid_last : pend_last;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef LANE_FETCH_ZERO_PAD_EN
        assign pad_data[8*i +: 8] = load_mask[i] ? load_data[8*i +: 8] : 8'h00;
`else
        assign pad_data[8*i +: 8] = load_data[8*i +: 8];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_vld   <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            skid_mask  <= '0;
            data_out   <= '0;
            valid_data <= '0;
            out_last   <= 1'b0;
        end else if (stall) begin
            // Output holds; a read issued before the stall lands here instead.
            if (pend_vld) begin
                skid_vld  <= 1'b1;
                skid_data <= bram_rdata;
                skid_mask <= pend_mask;
                skid_last <= pend_last;
            end
        end else begin
            skid_vld   <= 1'b0;
            data_out   <= load_vld ? pad_data : '0;
            valid_data <= load_vld ? load_mask : '0;
            out_last   <= load_vld && load_last;
        end
    end

endmodule

// File: tb/tb_bram_lane_fetch.sv
// Directed bench for bram_lane_fetch: streaming tiles, stall/skid, empty tile, start filtering and reset abort.
// Expected data follows LANE_FETCH_ZERO_PAD_EN the same way as the design build.

module tb_bram_lane_fetch;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [11:0]  base_addr;
    logic [15:0]  num_bytes;
    logic         stall;
    logic         bram_en;
    logic [11:0]  bram_addr;
    logic [127:0] bram_rdata;
    logic [127:0] data_out;
    logic [15:0]  valid_data;
    logic         busy;
    logic         done;

    int vec_cnt  = 0;
    int miss_cnt = 0;

`ifdef LANE_FETCH_ZERO_PAD_EN
    localparam logic [7:0] DEAD_LANE = 8'h00;
`else
    localparam logic [7:0] DEAD_LANE = 8'hFF;
`endif

    bram_lane_fetch #(.ADDR_W(12), .LANES(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_bytes(num_bytes), .stall(stall), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_rdata(bram_rdata), .data_out(data_out), .valid_data(valid_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word_of(input logic [11:0] a);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = a[7:0] + 8'(a[11:8] * 7) + 8'(i * 17);
        return w;
    endfunction

    // Masked-off lanes read as zero when padding is built in, raw otherwise.
    function automatic logic [127:0] exp_data(input logic [11:0] a, input logic [15:0] m);
        logic [127:0] keep;
        for (int i = 0; i < 16; i++) keep[8*i +: 8] = m[i] ? 8'hFF : DEAD_LANE;
        return word_of(a) & keep;
    endfunction

    // Synchronous-read BRAM; garbage when not enabled so a wrong-cycle capture shows up.
    always @(posedge clk) bram_rdata <= bram_en ? word_of(bram_addr) : {8{16'hDEAD}};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; base_addr = '0; num_bytes = '0;
        cyc(); cyc();
        #1;
        vec_cnt++;
        if ({bram_en, bram_addr, data_out, valid_data, busy, done} !== '0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got en=%b addr=%h vld=%h busy=%b done=%b data=%h want all zero",
                     bram_en, bram_addr, valid_data, busy, done, data_out);
        end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_streaming();
        logic [11:0] bases[3] = '{12'h010, 12'h020, 12'hFFF};
        logic [15:0] nbs[3]   = '{16'd48, 16'd20, 16'd32};
        int          nws[3]   = '{3, 2, 2};
        logic [15:0] lms[3]   = '{16'hFFFF, 16'h000F, 16'hFFFF};
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c <= nws[t] + 4; c++) begin
                int          j;
                logic        e_en, e_busy, e_done;
                logic [11:0] e_addr;
                logic [15:0] e_vld;
                cyc();
                start     = (c == 0);
                base_addr = bases[t];
                num_bytes = nbs[t];
                #1;
                j      = c - 3;
                e_en   = (c >= 1) && (c <= nws[t]);
                e_addr = bases[t] + 12'(c - 1);
                e_vld  = (j >= 0 && j < nws[t]) ? ((j == nws[t] - 1) ? lms[t] : 16'hFFFF) : 16'h0;
                e_busy = (c >= 1) && (c <= nws[t] + 2);
                e_done = (c == nws[t] + 3);
                vec_cnt++;
                if (bram_en !== e_en) begin
                    miss_cnt++;
                    $display("FAIL stream_en t%0d c%0d: got %b want %b", t, c, bram_en, e_en);
                end
                if (e_en) begin
                    vec_cnt++;
                    if (bram_addr !== e_addr) begin
                        miss_cnt++;
                        $display("FAIL stream_addr t%0d c%0d: got %h want %h", t, c, bram_addr, e_addr);
                    end
                end
                vec_cnt++;
                if (valid_data !== e_vld) begin
                    miss_cnt++;
                    $display("FAIL stream_valid t%0d c%0d: got %h want %h", t, c, valid_data, e_vld);
                end
                if (e_vld != 0) begin
                    vec_cnt++;
                    if (data_out !== exp_data(bases[t] + 12'(j), e_vld)) begin
                        miss_cnt++;
                        $display("FAIL stream_data t%0d c%0d: got %h want %h", t, c, data_out,
                                 exp_data(bases[t] + 12'(j), e_vld));
                    end
                end
                vec_cnt++;
                if ({busy, done} !== {e_busy, e_done}) begin
                    miss_cnt++;
                    $display("FAIL stream_busy_done t%0d c%0d: got %b%b want %b%b", t, c, busy, done, e_busy, e_done);
                end
            end
        end
    endtask

    task automatic test_stall();
        int aidx[13] = '{-1, 0, 1, 2, -1, -1, -1, -1, 3, -1, -1, -1, -1};
        int widx[13] = '{-1, -1, -1, 0, 1, 1, 1, 1, 2, -1, 3, -1, -1};
        bit stl[13]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        for (int c = 0; c < 13; c++) begin
            cyc();
            stall     = stl[c];
            start     = (c == 0) || (c == 5);
            base_addr = (c == 5) ? 12'h3AA : 12'h100;
            num_bytes = (c == 5) ? 16'd16 : 16'd64;
            #1;
            vec_cnt++;
            if (bram_en !== (aidx[c] >= 0)) begin
                miss_cnt++;
                $display("FAIL stall_en c%0d: got %b want %b", c, bram_en, aidx[c] >= 0);
            end
            if (aidx[c] >= 0) begin
                vec_cnt++;
                if (bram_addr !== 12'h100 + 12'(aidx[c])) begin
                    miss_cnt++;
                    $display("FAIL stall_addr c%0d: got %h want %h", c, bram_addr, 12'h100 + 12'(aidx[c]));
                end
            end
            vec_cnt++;
            if (valid_data !== ((widx[c] >= 0) ? 16'hFFFF : 16'h0)) begin
                miss_cnt++;
                $display("FAIL stall_valid c%0d: got %h want %h", c, valid_data,
                         (widx[c] >= 0) ? 16'hFFFF : 16'h0);
            end
            if (widx[c] >= 0) begin
                vec_cnt++;
                if (data_out !== word_of(12'h100 + 12'(widx[c]))) begin
                    miss_cnt++;
                    $display("FAIL stall_data c%0d: got %h want %h", c, data_out, word_of(12'h100 + 12'(widx[c])));
                end
            end
            vec_cnt++;
            if ({busy, done} !== {(c >= 1 && c <= 10), (c == 11)}) begin
                miss_cnt++;
                $display("FAIL stall_busy_done c%0d: got %b%b want %b%b", c, busy, done, (c >= 1 && c <= 10), (c == 11));
            end
        end
        stall = 1'b0; start = 1'b0;
    endtask

    task automatic test_zero_len();
        for (int c = 0; c < 4; c++) begin
            cyc();
            // The second start lands in the FINISH cycle and must be dropped.
            start     = (c == 0) || (c == 1);
            base_addr = 12'h055;
            num_bytes = (c == 0) ? 16'd0 : 16'd16;
            #1;
            vec_cnt++;
            if ({bram_en, valid_data, busy} !== '0) begin
                miss_cnt++;
                $display("FAIL zero_quiet c%0d: got en=%b vld=%h busy=%b want 0 0000 0", c, bram_en, valid_data, busy);
            end
            vec_cnt++;
            if (done !== (c == 1)) begin
                miss_cnt++;
                $display("FAIL zero_done c%0d: got %b want %b", c, done, c == 1);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5; c++) begin
            cyc();
            start = (c == 0); base_addr = 12'h200; num_bytes = 16'd64;
            #1;
            if (c == 4) begin
                vec_cnt++;
                if (valid_data !== 16'hFFFF || data_out !== word_of(12'h201)) begin
                    miss_cnt++;
                    $display("FAIL rstmid_word2: got vld=%h data=%h want FFFF %h", valid_data, data_out, word_of(12'h201));
                end
                reset_n = 1'b0;
            end
        end
        for (int c = 0; c < 2; c++) begin
            cyc();
            vec_cnt++;
            if ({bram_en, bram_addr, data_out, valid_data, busy, done} !== '0) begin
                miss_cnt++;
                $display("FAIL rstmid_zero r%0d: got en=%b addr=%h vld=%h busy=%b done=%b want all zero",
                         c, bram_en, bram_addr, valid_data, busy, done);
            end
        end
        reset_n = 1'b1;
        cyc();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rstmid_released: got busy=%b done=%b want 0 0", busy, done);
        end
        for (int c = 0; c < 6; c++) begin
            cyc();
            start = (c == 0); base_addr = 12'h300; num_bytes = 16'd16;
            #1;
            vec_cnt++;
            if ({bram_en, busy, done} !== {(c == 1), (c >= 1 && c <= 3), (c == 4)}) begin
                miss_cnt++;
                $display("FAIL rstmid_new c%0d: got en/busy/done=%b%b%b want %b%b%b", c, bram_en, busy, done,
                         (c == 1), (c >= 1 && c <= 3), (c == 4));
            end
            vec_cnt++;
            if (valid_data !== ((c == 3) ? 16'hFFFF : 16'h0) || (c == 3 && data_out !== word_of(12'h300))) begin
                miss_cnt++;
                $display("FAIL rstmid_new_word c%0d: got vld=%h data=%h want %h %h", c, valid_data, data_out,
                         (c == 3) ? 16'hFFFF : 16'h0, word_of(12'h300));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_zero_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
